// File: rtl/ei_axi4_pkg.sv
// ei_axi4_pkg: shared state type, index-width helper and AXI4 burst limit
// for the AXI4 write arbiter.
package ei_axi4_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} arb_state_e;
   localparam int AXI4_MAX_LEN = 255;
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/ei_axi4_rr_pick.sv
// ei_axi4_rr_pick: combinational round-robin picker; selects the first
// requester at or after ptr, wrapping cyclically.
module ei_axi4_rr_pick
   import ei_axi4_pkg::*;
#(
   parameter int N = 4,
   parameter int IDX_W = idx_w(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] idx,
   output logic             any_req
);
   logic [IDX_W-1:0] lo, hi;
   logic             hi_v;
   // Descending scan: lowest requester overall, and lowest at or above ptr
   always_comb begin
      lo = '0;
      hi = '0;
      hi_v = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            lo = IDX_W'(i);
            if (IDX_W'(i) >= ptr) begin
               hi = IDX_W'(i);
               hi_v = 1'b1;
            end
         end
      end
   end
   assign idx = hi_v ? hi : lo;
   assign any_req = |req;
endmodule

// File: rtl/ei_axi4_wr_arbiter.sv
// ei_axi4_wr_arbiter: round-robin AXI4 AW+W arbiter with burst-locked grant and
// beat-count check. Optional stall timeout via EI_AXI4_ARB_TIMEOUT_EN.
module ei_axi4_wr_arbiter
   import ei_axi4_pkg::*;
#(
   parameter int NUM_MST = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH = 4,
`ifdef EI_AXI4_ARB_TIMEOUT_EN
   parameter int TIMEOUT_CYC = 256,
`endif
   localparam int IDX_W = idx_w(NUM_MST)
) (
   input  logic                            aclk,
   input  logic                            areset,
   input  logic [NUM_MST-1:0]              m_awvalid,
   output logic [NUM_MST-1:0]              m_awready,
   input  logic [NUM_MST*ADDR_WIDTH-1:0]   m_awaddr,
   input  logic [NUM_MST*ID_WIDTH-1:0]     m_awid,
   input  logic [NUM_MST*8-1:0]            m_awlen,
   input  logic [NUM_MST-1:0]              m_wvalid,
   output logic [NUM_MST-1:0]              m_wready,
   input  logic [NUM_MST*DATA_WIDTH-1:0]   m_wdata,
   input  logic [NUM_MST*DATA_WIDTH/8-1:0] m_wstrb,
   input  logic [NUM_MST-1:0]              m_wlast,
   output logic                            s_awvalid,
   input  logic                            s_awready,
   output logic [ADDR_WIDTH-1:0]           s_awaddr,
   output logic [ID_WIDTH+IDX_W-1:0]       s_awid,
   output logic [7:0]                      s_awlen,
   output logic                            s_wvalid,
   input  logic                            s_wready,
   output logic [DATA_WIDTH-1:0]           s_wdata,
   output logic [DATA_WIDTH/8-1:0]         s_wstrb,
   output logic                            s_wlast,
   output logic [IDX_W-1:0]                grant_idx,
`ifdef EI_AXI4_ARB_TIMEOUT_EN
   output logic                            timeout,
`endif
   output logic                            len_err
);
   localparam int LEN_W = $clog2(AXI4_MAX_LEN + 1);
   arb_state_e state_q, state_d;
   logic [IDX_W-1:0] grant_q, grant_d, rr_q, rr_d, pick_idx, next_ptr;
   logic [LEN_W-1:0] awlen_q, awlen_d, beat_q, beat_d;
   logic len_err_q, len_err_d, any_req, in_addr, in_data, aw_hs, w_hs;
`ifdef EI_AXI4_ARB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TO_W-1:0] stall_q, stall_d;
   logic timeout_q, timeout_d;
   assign timeout = timeout_q;
`endif

   ei_axi4_rr_pick #(.N(NUM_MST), .IDX_W(IDX_W)) u_pick (
      .req(m_awvalid), .ptr(rr_q), .idx(pick_idx), .any_req(any_req)
   );

   assign in_addr = state_q == ADDR;
   assign in_data = state_q == DATA;
   // Slave-side fields are forced to zero outside their phase
   assign s_awvalid = in_addr & m_awvalid[grant_q];
   assign s_awaddr = in_addr ? m_awaddr[grant_q*ADDR_WIDTH +: ADDR_WIDTH] : '0;
   assign s_awid = in_addr ? {grant_q, m_awid[grant_q*ID_WIDTH +: ID_WIDTH]} : '0;
   assign s_awlen = in_addr ? m_awlen[grant_q*8 +: 8] : '0;
   assign s_wvalid = in_data & m_wvalid[grant_q];
   assign s_wdata = in_data ? m_wdata[grant_q*DATA_WIDTH +: DATA_WIDTH] : '0;
   assign s_wstrb = in_data ? m_wstrb[grant_q*(DATA_WIDTH/8) +: DATA_WIDTH/8] : '0;
   assign s_wlast = in_data & m_wlast[grant_q];
   assign aw_hs = s_awvalid & s_awready;
   assign w_hs = s_wvalid & s_wready;
   assign next_ptr = (grant_q == IDX_W'(NUM_MST - 1)) ? '0 : grant_q + 1'b1;
   assign grant_idx = grant_q;
   assign len_err = len_err_q;

   always_comb begin
      m_awready = '0;
      m_wready = '0;
      m_awready[grant_q] = in_addr & s_awready;
      m_wready[grant_q] = in_data & s_wready;
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      rr_d = rr_q;
      awlen_d = awlen_q;
      beat_d = beat_q;
      len_err_d = w_hs & (s_wlast ? beat_q != awlen_q : beat_q == awlen_q);
      if (state_q == IDLE && any_req) begin
         state_d = ADDR;
         grant_d = pick_idx;
      end
      if (aw_hs) begin
         state_d = DATA;
         awlen_d = s_awlen;
         beat_d = '0;
      end
      if (w_hs) begin
         beat_d = beat_q + 1'b1;
         if (s_wlast) begin
            state_d = IDLE;
            rr_d = next_ptr;
         end
      end
`ifdef EI_AXI4_ARB_TIMEOUT_EN
      stall_d = ((in_addr || in_data) && !aw_hs && !w_hs) ? stall_q + 1'b1 : '0;
      timeout_d = stall_d == TO_W'(TIMEOUT_CYC);
      if (timeout_d) begin
         state_d = IDLE;
         rr_d = next_ptr;
         stall_d = '0;
      end
`endif
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q <= IDLE;
         grant_q <= '0;
         rr_q <= '0;
         awlen_q <= '0;
         beat_q <= '0;
         len_err_q <= 1'b0;
`ifdef EI_AXI4_ARB_TIMEOUT_EN
         stall_q <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         rr_q <= rr_d;
         awlen_q <= awlen_d;
         beat_q <= beat_d;
         len_err_q <= len_err_d;
`ifdef EI_AXI4_ARB_TIMEOUT_EN
         stall_q <= stall_d;
         timeout_q <= timeout_d;
`endif
      end
   end
endmodule

// File: tb/tb_ei_axi4_wr_arbiter.sv
// tb_ei_axi4_wr_arbiter: directed stimulus with a queue-based scoreboard on the
// slave AW/W channels; timeout scenario built only with EI_AXI4_ARB_TIMEOUT_EN.
module tb_ei_axi4_wr_arbiter;
   logic aclk = 1'b0, areset;
   logic [3:0] m_awvalid, m_awready, m_wvalid, m_wready, m_wlast;
   logic [127:0] m_awaddr, m_wdata;
   logic [15:0] m_awid, m_wstrb;
   logic [31:0] m_awlen;
   logic s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, len_err;
   logic [31:0] s_awaddr, s_wdata;
   logic [5:0] s_awid;
   logic [7:0] s_awlen;
   logic [3:0] s_wstrb;
   logic [1:0] grant_idx;
`ifdef EI_AXI4_ARB_TIMEOUT_EN
   logic timeout;
`endif
   logic [63:0] awq[$], wq[$];
   int n_cmp = 0, n_bad = 0, len_err_cnt = 0;

   ei_axi4_wr_arbiter dut (
      .aclk(aclk), .areset(areset),
      .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
      .m_awid(m_awid), .m_awlen(m_awlen), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
      .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
      .s_awid(s_awid), .s_awlen(s_awlen), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .grant_idx(grant_idx),
`ifdef EI_AXI4_ARB_TIMEOUT_EN
      .timeout(timeout),
`endif
      .len_err(len_err)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] wd(input int m, input int b);
      return 32'hD000_0000 | 32'(m << 12) | 32'(b);
   endfunction

   function automatic logic [3:0] ws(input int b);
      return 4'(b + 1);
   endfunction

   task automatic push_exp(input int m, input logic [31:0] addr, input logic [3:0] id,
                           input logic [7:0] len, input int nbeats, input int nsend);
      logic [1:0] mi;
      mi = 2'(m);
      awq.push_back(64'({mi, id, addr, len}));
      for (int b = 0; b < nsend; b++) wq.push_back(64'({wd(m, b), ws(b), b == nbeats - 1}));
   endtask

   task automatic wait_rdy(input int m, input bit is_w);
      int n;
      n = 0;
      do begin
         @(negedge aclk);
         n++;
      end while (!(is_w ? m_wready[m] : m_awready[m]) && n < 400);
      if (!(is_w ? m_wready[m] : m_awready[m])) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_ready m%0d w=%0d: ready 0 after %0d cycles, required 1", m, is_w, n);
      end else begin
         @(posedge aclk);
         #1;
      end
   endtask

   task automatic burst(input int m, input logic [31:0] addr, input logic [3:0] id,
                        input logic [7:0] len, input int nbeats, input int nsend);
      m_awvalid[m] = 1'b1;
      m_awaddr[m*32 +: 32] = addr;
      m_awid[m*4 +: 4] = id;
      m_awlen[m*8 +: 8] = len;
      wait_rdy(m, 1'b0);
      m_awvalid[m] = 1'b0;
      for (int b = 0; b < nsend; b++) begin
         m_wvalid[m] = 1'b1;
         m_wdata[m*32 +: 32] = wd(m, b);
         m_wstrb[m*4 +: 4] = ws(b);
         m_wlast[m] = b == nbeats - 1;
         wait_rdy(m, 1'b1);
      end
      m_wvalid[m] = 1'b0;
      m_wlast[m] = 1'b0;
   endtask

   // Scoreboard monitor: pops an expectation on every slave-side handshake
   always @(negedge aclk) begin
      if (!areset) begin
         if (s_awvalid && s_awready) begin
            if (awq.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL aw_unexpected: got awid %h addr %h, required no transfer", s_awid, s_awaddr);
            end else chk("aw", 64'({s_awid, s_awaddr, s_awlen}), awq.pop_front());
         end
         if (s_wvalid && s_wready) begin
            if (wq.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL w_unexpected: got wdata %h, required no transfer", s_wdata);
            end else chk("w", 64'({s_wdata, s_wstrb, s_wlast}), wq.pop_front());
         end
         if (len_err) len_err_cnt++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      areset = 1'b1;
      m_awvalid = '0; m_wvalid = '0; m_wlast = '0;
      m_awaddr = '0; m_wdata = '0; m_awid = '0; m_wstrb = '0; m_awlen = '0;
      s_awready = 1'b1;
      s_wready = 1'b1;
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      chk("reset_outputs", 64'({s_awvalid, s_wvalid, m_awready, m_wready, len_err, grant_idx,
                                s_awaddr, s_awid, s_wlast}), 64'd0);
      @(posedge aclk);
      #1 areset = 1'b0;
      // Idle with early W data from m1: nothing may be accepted
      m_wvalid[1] = 1'b1;
      repeat (10) begin
         @(negedge aclk);
         chk("idle", 64'({s_awvalid, s_wvalid, m_awready, m_wready}), 64'd0);
      end
      @(posedge aclk);
      #1 m_wvalid[1] = 1'b0;
      // Four masters contend: grant order 0,1,2,3,0
      push_exp(0, 32'h1000_0000, 4'h1, 8'd0, 1, 1);
      push_exp(1, 32'h1000_0100, 4'h2, 8'd0, 1, 1);
      push_exp(2, 32'h1000_0200, 4'h3, 8'd0, 1, 1);
      push_exp(3, 32'h1000_0300, 4'h4, 8'd0, 1, 1);
      push_exp(0, 32'h1000_0400, 4'h6, 8'd0, 1, 1);
      fork
         begin
            burst(0, 32'h1000_0000, 4'h1, 8'd0, 1, 1);
            burst(0, 32'h1000_0400, 4'h6, 8'd0, 1, 1);
         end
         burst(1, 32'h1000_0100, 4'h2, 8'd0, 1, 1);
         burst(2, 32'h1000_0200, 4'h3, 8'd0, 1, 1);
         burst(3, 32'h1000_0300, 4'h4, 8'd0, 1, 1);
      join
      // m0 awlen=3, awid=5: one-cycle grant latency
      push_exp(0, 32'h2000_0040, 4'h5, 8'd3, 4, 4);
      fork
         burst(0, 32'h2000_0040, 4'h5, 8'd3, 4, 4);
         begin
            @(posedge aclk);
            @(negedge aclk);
            chk("latency_awvalid", s_awvalid, 1);
            chk("latency_awid", s_awid, 6'h05);
         end
      join
      @(negedge aclk);
      chk("len_ok", len_err, 0);
      @(posedge aclk);
      #1;
      // m2 early WLAST on beat 2 of awlen=3
      push_exp(2, 32'h3000_0000, 4'h9, 8'd3, 3, 3);
      burst(2, 32'h3000_0000, 4'h9, 8'd3, 3, 3);
      @(negedge aclk);
      chk("len_err_pulse", len_err, 1);
      chk("early_end_idle", 64'({s_awvalid, s_wvalid, m_wready}), 64'd0);
      @(negedge aclk);
      chk("len_err_once", len_err, 0);
      @(posedge aclk);
      #1;
      // s_awready low 5 cycles with m1 and m3 requesting; rr_ptr=3 picks m3
      s_awready = 1'b0;
      push_exp(3, 32'h4000_0000, 4'hA, 8'd1, 2, 2);
      push_exp(1, 32'h4000_0100, 4'hB, 8'd0, 1, 1);
      fork
         burst(3, 32'h4000_0000, 4'hA, 8'd1, 2, 2);
         burst(1, 32'h4000_0100, 4'hB, 8'd0, 1, 1);
         begin
            @(posedge aclk);
            repeat (5) begin
               @(negedge aclk);
               chk("aw_stall_hold", 64'({s_awvalid, grant_idx, m_awready}), 64'({1'b1, 2'd3, 4'b0000}));
            end
            @(posedge aclk);
            #1 s_awready = 1'b1;
         end
      join
      // Reset in the middle of a DATA burst
      push_exp(0, 32'h6000_0000, 4'hC, 8'd7, 8, 2);
      burst(0, 32'h6000_0000, 4'hC, 8'd7, 8, 2);
      areset = 1'b1;
      @(posedge aclk);
      @(negedge aclk);
      chk("reset_mid_burst", 64'({m_awready, m_wready, s_awvalid, s_wvalid, grant_idx}), 64'd0);
      @(posedge aclk);
      #1 areset = 1'b0;
      push_exp(2, 32'h7000_0000, 4'hD, 8'd0, 1, 1);
      fork
         burst(2, 32'h7000_0000, 4'hD, 8'd0, 1, 1);
         begin
            @(posedge aclk);
            @(negedge aclk);
            chk("recover_grant", grant_idx, 2);
         end
      join
`ifdef EI_AXI4_ARB_TIMEOUT_EN
      begin : timeout_test
         int n;
         push_exp(0, 32'h5000_0000, 4'h1, 8'd0, 1, 0);
         m_awvalid[0] = 1'b1;
         m_awaddr[31:0] = 32'h5000_0000;
         m_awid[3:0] = 4'h1;
         m_awlen[7:0] = 8'd0;
         wait_rdy(0, 1'b0);
         m_awvalid[0] = 1'b0;
         m_wvalid[0] = 1'b1;
         m_wlast[0] = 1'b1;
         s_wready = 1'b0;
         m_awvalid[1] = 1'b1;
         m_awaddr[63:32] = 32'h5000_0100;
         m_awid[7:4] = 4'h2;
         m_awlen[15:8] = 8'd0;
         n = 0;
         do begin
            @(negedge aclk);
            n++;
         end while (!timeout && n < 400);
         chk("timeout_seen", timeout, 1);
         push_exp(1, 32'h5000_0100, 4'h2, 8'd0, 1, 1);
         @(posedge aclk);
         #1;
         m_wvalid[0] = 1'b0;
         m_wlast[0] = 1'b0;
         s_wready = 1'b1;
         fork
            burst(1, 32'h5000_0100, 4'h2, 8'd0, 1, 1);
            begin
               @(negedge aclk);
               chk("timeout_once", timeout, 0);
               chk("timeout_next_grant", grant_idx, 1);
            end
         join
      end
`endif
      repeat (3) @(negedge aclk);
      chk("aw_queue_drained", awq.size(), 0);
      chk("w_queue_drained", wq.size(), 0);
      chk("len_err_count", len_err_cnt, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
